// File: rtl/shift_exec_pipe_pkg.sv
// Shared constants for the execute-stage shift pipeline: shifter mode
// encodings and operand forwarding selects.
package shift_exec_pipe_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/shift_exec_pipe_shifter.sv
// 16-bit combinational barrel shifter: SLL, SRA, ROR; mode 11 passes the
// operand through unchanged.
module shift_exec_pipe_shifter
    import shift_exec_pipe_pkg::*;
(
    input  logic [15:0] Shift_In,
    input  logic [1:0]  Mode_In,
    input  logic [3:0]  Shift_Val,
    output logic [15:0] Shift_Out
);

    // Select the shifted value for the requested mode.
    always_comb begin
        // NOTE: default assignment first so every path drives Shift_Out and no latch is inferred.
        Shift_Out = Shift_In;
        case (Mode_In)
            MODE_SLL: Shift_Out = Shift_In << Shift_Val;
            MODE_SRA: Shift_Out = $signed(Shift_In) >>> Shift_Val;
            // A left shift by 16 of a 16-bit value is zero, so amount 0 yields Shift_In.
            MODE_ROR: Shift_Out = (Shift_In >> Shift_Val) | (Shift_In << (5'd16 - {1'b0, Shift_Val}));
            MODE_ILL: Shift_Out = Shift_In;
        endcase
    end

endmodule

// File: rtl/shift_exec_pipe.sv
// Execute-stage shift wrapper: stage 1 operand register (forwarding resolved
// at acceptance) feeding the barrel shifter, stage 2 result register with Z
// flag, illegal-mode flag and destination tag. Valid/ready on both sides,
// flush kills all in-flight ops.
// Optional: define SHIFT_STALL_CNT_EN to add a saturating stall_cnt output
// counting cycles with out_valid && !out_ready.
module shift_exec_pipe
    import shift_exec_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_mode,
    input  logic [DATA_W-1:0] in_src,
    input  logic [3:0]        in_shamt,
    input  logic [TAG_W-1:0]  in_dst,
    input  logic [1:0]        in_fwd_sel,
    input  logic [DATA_W-1:0] fwd_exmem_data,
    input  logic [DATA_W-1:0] fwd_memwb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_dst,
    output logic              out_z,
    output logic              out_err
`ifdef SHIFT_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // Stage 1: operand register
    logic              s1_v;
    logic [DATA_W-1:0] s1_src;
    logic [1:0]        s1_mode;
    logic [3:0]        s1_shamt;
    logic [TAG_W-1:0]  s1_dst;

    // Stage 2 valid; the payload registers are the outputs themselves
    logic              s2_v;

    logic              s2_adv;
    logic              s1_adv;
    logic [DATA_W-1:0] sel_src;
    logic [DATA_W-1:0] shift_out;

    // Handshake: a stage moves when the stage ahead of it can take its contents.
    always_comb begin
        s2_adv   = !s2_v || out_ready;
        s1_adv   = s2_adv;
        in_ready = !s1_v || s1_adv;
    end

    // Forwarding mux, resolved when the op is accepted.
    always_comb begin
        sel_src = in_src;
        case (in_fwd_sel)
            FWD_RF:    sel_src = in_src;
            FWD_EXMEM: sel_src = fwd_exmem_data;
            FWD_MEMWB: sel_src = fwd_memwb_data;
            default:   sel_src = in_src;
        endcase
    end

    // Stage 1 valid: reset and flush clear it, otherwise it follows in_valid whenever a slot is open.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            s1_v <= 1'b0;
        end else if (flush) begin
            s1_v <= 1'b0;
        end else if (in_ready) begin
            s1_v <= in_valid;
        end
    end

    // Stage 1 payload: loads only on a real acceptance.
    always_ff @(posedge clk) begin
        // NOTE: payload registers carry no reset; s1_v qualifies them, so their reset value is never observed.
        if (!flush && in_ready && in_valid) begin
            s1_src   <= sel_src;
            s1_mode  <= in_mode;
            s1_shamt <= in_shamt;
            s1_dst   <= in_dst;
        end
    end

    shift_exec_pipe_shifter u_shifter (
        .Shift_In  (s1_src),
        .Mode_In   (s1_mode),
        .Shift_Val (s1_shamt),
        .Shift_Out (shift_out)
    );

    // Stage 2 result register: captures shifter output, flags and tag; holds under back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v     <= 1'b0;
            out_data <= '0;
            out_dst  <= '0;
            out_z    <= 1'b0;
            out_err  <= 1'b0;
        end else if (flush) begin
            s2_v <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                out_data <= shift_out;
                out_dst  <= s1_dst;
                out_z    <= (shift_out == '0);
                out_err  <= (s1_mode == MODE_ILL);
            end
        end
    end

    assign out_valid = s2_v;

`ifdef SHIFT_STALL_CNT_EN
    // Saturating count of back-pressured output cycles; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (s2_v && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Self-checking bench for shift_exec_pipe: directed cases plus randomized
// traffic against an in-order queue model of the pipeline.
module tb_shift_exec_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [15:0] in_src;
    logic [3:0]  in_shamt;
    logic [3:0]  in_dst;
    logic [1:0]  in_fwd_sel;
    logic [15:0] fwd_exmem_data;
    logic [15:0] fwd_memwb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_dst;
    logic        out_z;
    logic        out_err;
`ifdef SHIFT_STALL_CNT_EN
    logic [15:0] stall_cnt;
    int          stall_exp = 0;
`endif

    always #5 clk = ~clk;

    shift_exec_pipe #(.DATA_W(16), .TAG_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mode        (in_mode),
        .in_src         (in_src),
        .in_shamt       (in_shamt),
        .in_dst         (in_dst),
        .in_fwd_sel     (in_fwd_sel),
        .fwd_exmem_data (fwd_exmem_data),
        .fwd_memwb_data (fwd_memwb_data),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_dst        (out_dst),
        .out_z          (out_z),
        .out_err        (out_err)
`ifdef SHIFT_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: ops leave in acceptance order, one per cycle at most, and each
    // must spend at least one full cycle inside before it can be seen.
    typedef struct {
        logic [15:0] data;
        logic [3:0]  dst;
        logic        z;
        logic        err;
        int          stamp;
    } op_t;

    op_t q[$];
    int  edges = 0;

    // Reference shift from plain integer arithmetic.
    function automatic logic [15:0] ref_shift(input logic [1:0] m, input logic [15:0] v, input int sh);
        longint x;
        longint p;
        longint s;
        x = longint'(v);
        p = longint'(1) << sh;
        case (m)
            2'b00: return 16'((x * p) % 65536);
            2'b01: begin
                s = (x >= 32768) ? x - 65536 : x;
                s = (s >= 0) ? s / p : -((-s + p - 1) / p);
                return 16'((s + 65536) % 65536);
            end
            2'b10: return 16'((x % p) * (65536 / p) + x / p);
            default: return v;
        endcase
    endfunction

    function automatic bit head_visible();
        return (q.size() > 0) && (edges > q[0].stamp);
    endfunction

    // One clock cycle: drive inputs at negedge, check in_ready, advance the
    // model at the edge, then check outputs on the following negedge.
    task automatic step(input logic v, input logic [1:0] m, input logic [15:0] s,
                        input logic [3:0] sh, input logic [3:0] d, input logic [1:0] fs,
                        input logic [15:0] ex, input logic [15:0] mw,
                        input logic ordy, input logic fl, input logic rs);
        bit   ready_exp;
        bit   pop;
        bit   acc;
        op_t  op;
        logic [15:0] opnd;
        rst = rs; flush = fl; in_valid = v; in_mode = m; in_src = s; in_shamt = sh;
        in_dst = d; in_fwd_sel = fs; fwd_exmem_data = ex; fwd_memwb_data = mw; out_ready = ordy;
        #1;
        ready_exp = (q.size() < 2) || ordy;
        if (!rs) check("in_ready", in_ready, ready_exp);
        pop = head_visible() && ordy;
        acc = v && ready_exp;
        opnd = (fs == 2'b01) ? ex : (fs == 2'b10) ? mw : s;
`ifdef SHIFT_STALL_CNT_EN
        if (rs) stall_exp = 0;
        else if (head_visible() && !ordy && stall_exp < 65535) stall_exp++;
`endif
        @(posedge clk);
        edges++;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                op.data  = ref_shift(m, opnd, int'(sh));
                op.dst   = d;
                op.z     = (op.data == 16'h0);
                op.err   = (m == 2'b11);
                op.stamp = edges;
                q.push_back(op);
            end
        end
        @(negedge clk);
        check("out_valid", out_valid, head_visible());
        if (head_visible()) begin
            check("out_data", out_data, q[0].data);
            check("out_dst",  out_dst,  q[0].dst);
            check("out_z",    out_z,    q[0].z);
            check("out_err",  out_err,  q[0].err);
        end
`ifdef SHIFT_STALL_CNT_EN
        check("stall_cnt", stall_cnt, stall_exp[15:0]);
`endif
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 2'b00, 16'h0, 4'h0, 4'h0, 2'b00, 16'h0, 16'h0, ordy, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [1:0] m, input logic [15:0] s, input logic [3:0] sh,
                         input logic [3:0] d, input logic ordy);
        step(1'b1, m, s, sh, d, 2'b00, 16'h0, 16'h0, ordy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 16'h0, 4'h0, 4'h0, 2'b00, 16'h0, 16'h0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_data"},  out_data,  16'h0);
        check({tag, "_dst"},   out_dst,   4'h0);
        check({tag, "_z"},     out_z,     1'b0);
        check({tag, "_err"},   out_err,   1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        do_reset();
        check_zero_outputs("reset");

        // SLL basic, two-cycle latency
        issue(2'b00, 16'h00F1, 4'd4, 4'd3, 1'b1);
        check("sll_latency_s1", out_valid, 1'b0);
        idle(1'b1);
        check("sll_data", out_data, 16'h0F10);
        check("sll_z", out_z, 1'b0);
        idle(1'b1);

        // Back-to-back SRA and ROR
        issue(2'b01, 16'h8000, 4'd15, 4'd1, 1'b1);
        issue(2'b10, 16'h1234, 4'd8,  4'd2, 1'b1);
        check("sra_data", out_data, 16'hFFFF);
        idle(1'b1);
        check("ror_data", out_data, 16'h3412);
        check("ror_valid", out_valid, 1'b1);
        idle(1'b1);

        // Forwarding from EX/MEM, then a zero result
        step(1'b1, 2'b00, 16'hAAAA, 4'd15, 4'd5, 2'b01, 16'h0001, 16'h7777, 1'b1, 1'b0, 1'b0);
        issue(2'b00, 16'h8000, 4'd1, 4'd6, 1'b1);
        check("fwd_data", out_data, 16'h8000);
        idle(1'b1);
        check("zero_data", out_data, 16'h0000);
        check("zero_z", out_z, 1'b1);
        idle(1'b1);

        // Back-pressure: three ops offered, two accepted, then release
        issue(2'b00, 16'h0003, 4'd1, 4'd7, 1'b0);
        issue(2'b00, 16'h0005, 4'd2, 4'd8, 1'b0);
        issue(2'b00, 16'h0009, 4'd3, 4'd9, 1'b0);
        check("bp_in_ready", in_ready, 1'b0);
        issue(2'b00, 16'h0009, 4'd3, 4'd9, 1'b0);
        check("bp_hold", out_data, 16'h0006);
        issue(2'b00, 16'h0009, 4'd3, 4'd9, 1'b1);
        check("bp_second", out_data, 16'h0014);
        idle(1'b1);
        check("bp_third", out_data, 16'h0048);
        idle(1'b1);
        check("bp_drained", out_valid, 1'b0);

        // Flush with both stages full; op offered alongside is dropped
        issue(2'b00, 16'h0001, 4'd1, 4'd1, 1'b0);
        issue(2'b00, 16'h0001, 4'd2, 4'd2, 1'b0);
        step(1'b1, 2'b10, 16'hBEEF, 4'd4, 4'd3, 2'b00, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        check("flush_valid", out_valid, 1'b0);
        idle(1'b1);
        check("flush_dropped", out_valid, 1'b0);

        // Reset mid-stream
        issue(2'b10, 16'hF00F, 4'd4, 4'd9, 1'b0);
        issue(2'b01, 16'h8421, 4'd2, 4'd10, 1'b0);
        do_reset();
        check_zero_outputs("midrst");

        // Illegal mode and zero shift amounts
        issue(2'b11, 16'h5A5A, 4'd7, 4'd4, 1'b1);
        issue(2'b00, 16'hC3C3, 4'd0, 4'd1, 1'b1);
        check("ill_data", out_data, 16'h5A5A);
        check("ill_err", out_err, 1'b1);
        issue(2'b01, 16'hC3C3, 4'd0, 4'd1, 1'b1);
        check("sll0_data", out_data, 16'hC3C3);
        issue(2'b10, 16'hC3C3, 4'd0, 4'd1, 1'b1);
        check("sra0_data", out_data, 16'hC3C3);
        idle(1'b1);
        check("ror0_data", out_data, 16'hC3C3);
        idle(1'b1);

`ifdef SHIFT_STALL_CNT_EN
        do_reset();
        issue(2'b00, 16'h0001, 4'd1, 4'd1, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        check("stall_cnt_5", stall_cnt, 16'd5);
        idle(1'b1);
        idle(1'b1);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom),
                 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)),
                 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_exec_pipe.md
Name: shift_exec_pipe

Overview:
- Execute-stage wrapper around the 16-bit barrel shifter. Shifter modes: 00 SLL, 01 SRA, 10 ROR; shift amount 4 bits.
- Stage 1 is an operand register. It takes the decoded shift op from ID, resolves forwarding, and drives the shifter combinationally.
- Stage 2 is a result register. It captures the shifter output, a Z flag and the destination tag for the EX/MEM boundary.
- Both stages use valid/ready handshakes, with flush support.

Parameters:
DATA_W, 16, datapath width; only 16 is supported (matches shifter).
TAG_W, 4, destination register tag width.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  ID presents a shift op
in_ready  output  1  block accepts op this cycle
in_mode  input  2  shift mode (00 SLL, 01 SRA, 10 ROR, 11 illegal)
in_src  input  16  source operand from register file
in_shamt  input  4  shift amount
in_dst  input  TAG_W  destination tag
in_fwd_sel  input  2  00 in_src, 01 fwd_exmem_data, 10 fwd_memwb_data, 11 in_src
fwd_exmem_data  input  16  forwarded EX/MEM result
fwd_memwb_data  input  16  forwarded MEM/WB result
flush  input  1  kill all in-flight ops
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_data  output  16  shifted result
out_dst  output  TAG_W  destination tag
out_z  output  1  result == 0
out_err  output  1  op had illegal mode 11

Behaviour:
- Single clock; reset is synchronous and active-high. On rst, all valids, out_data, out_dst, out_z and out_err are 0.
- The forwarding mux is applied at acceptance. Stage 1 stores the selected operand, mode, shamt, dst and valid s1_v.
- Stage 1 drives the shifter with Shift_In=s1_src, Mode_In=s1_mode, Shift_Val=s1_shamt.
- Advance conditions:
  - s2_adv = !s2_v || out_ready.
  - s1_adv = s2_adv.
  - in_ready = !s1_v || s1_adv. in_ready is combinational and does not depend on in_valid.
- Stage 1 update: when in_ready is high, s1_v <= in_valid and the payload loads only if in_valid. Otherwise stage 1 holds.
- Stage 2 update: when s2_adv is high, s2_v <= s1_v, and out_data/out_dst/out_z/out_err load if s1_v. Otherwise stage 2 holds, and all outputs stay stable while out_valid && !out_ready.
- Latency: an op accepted at edge N appears with out_valid at edge N+1 after the stage-2 capture, i.e. 2 cycles from in_valid/in_ready to out_valid. Full throughput is 1 op/cycle with no bubbles when out_ready is held high.
- Mode 11:
  - The shifter passes the operand through unchanged.
  - out_err=1 with that result; out_z is still computed.
  - No trap is raised inside the block.
- Shift amount 0 in any mode gives an unchanged operand.
- SRA preserves bit 15. ROR by 8 swaps bytes.
- Flush:
  - On flush, s1_v and s2_v clear at the next edge, and any in_valid in the same cycle is dropped.
  - in_ready may still read 1 during flush, but nothing is captured.
  - Flush takes priority over advance/load.
  - Payload registers are don't-care after flush; out_data is not required to clear.
- If rst and flush are both high, rst wins (identical effect on valids).
- Back-pressure: with out_ready low, the block holds at most 2 ops, then in_ready goes low.

Optional Feature:
- Macro SHIFT_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - The counter increments each cycle out_valid && !out_ready and saturates at 16'hFFFF.
  - It clears on rst only, not on flush.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Mode constants MODE_SLL=2'b00, MODE_SRA=2'b01, MODE_ROR=2'b10, MODE_ILL=2'b11.
  - Forward-select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10.
- The existing 16-bit barrel shifter is instantiated unchanged as the one sub-module; no new sub-module is needed.
- Stage registers and the handshake stay in this module.

Test Plan:
- Mode SLL, src=16'h00F1, shamt=4, fwd=00, out_ready=1 -> after 2 cycles out_valid=1, out_data=16'h0F10, out_z=0, out_err=0.
- Mode SRA, src=16'h8000, shamt=15 -> out_data=16'hFFFF; mode ROR, src=16'h1234, shamt=8 -> 16'h3412; back-to-back issue gives results on consecutive cycles.
- Mode SLL, fwd=01, fwd_exmem_data=16'h0001, in_src=16'hAAAA, shamt=15 -> out_data=16'h8000; a second op with SLL, shamt=1 on 16'h8000 -> out_data=0, out_z=1.
- out_ready=0 with 3 ops offered -> in_ready drops after 2 accepts and out_data stays stable; on release, results emerge in order with none lost or duplicated.
- flush asserted with both stages full -> next cycle out_valid=0 and the in_valid op that cycle is not captured; rst mid-stream -> all outputs 0 next cycle.
- Mode 11, src=16'h5A5A -> out_data=16'h5A5A, out_err=1. With SHIFT_STALL_CNT_EN, 5 cycles of out_valid && !out_ready -> stall_cnt=5.
